// File: rtl/normalize_arb_pkg.sv
// Shared types and constants for the normalize-unit arbiter: FSM state encoding,
// Q16.16 word geometry and the default requester count.
package normalize_arb_pkg;

  localparam int Q_W         = 32;
  localparam int Q_FRAC      = 16;
  localparam logic [Q_W-1:0] Q_ONE = 32'h0001_0000;
  localparam int NUM_REQ_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/normalize_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, wrapping, returned both one-hot and as an index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        idx    = IDX_W'(j);
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/normalize_arbiter.sv
// Round-robin sharing of one normalize unit among NUM_REQ requesters, one operation
// in flight. Optional NRM_ARB_ZERO_BYPASS_EN answers all-zero vectors without the unit.
module normalize_arbiter
  import normalize_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = Q_W,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_vx,
  input  logic [NUM_REQ*DATA_W-1:0] req_vy,
  input  logic [NUM_REQ*DATA_W-1:0] req_vz,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         res_x,
  output logic [DATA_W-1:0]         res_y,
  output logic [DATA_W-1:0]         res_z,
  output logic                      nrm_start,
  output logic [DATA_W-1:0]         nrm_vx,
  output logic [DATA_W-1:0]         nrm_vy,
  output logic [DATA_W-1:0]         nrm_vz,
  input  logic                      nrm_finish,
  input  logic [DATA_W-1:0]         nrm_rx,
  input  logic [DATA_W-1:0]         nrm_ry,
  input  logic [DATA_W-1:0]         nrm_rz
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   rr_q;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [DATA_W-1:0]  sel_vx, sel_vy, sel_vz;
  logic               sel_zero;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req (req),
    .ptr (rr_q),
    .gnt (pick_oh),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign sel_vx = req_vx[pick_idx*DATA_W +: DATA_W];
  assign sel_vy = req_vy[pick_idx*DATA_W +: DATA_W];
  assign sel_vz = req_vz[pick_idx*DATA_W +: DATA_W];

`ifdef NRM_ARB_ZERO_BYPASS_EN
  assign sel_zero = (sel_vx == '0) && (sel_vy == '0) && (sel_vz == '0);
`else
  assign sel_zero = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    gnt        = '0;
    resp_valid = '0;
    nrm_start  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt     = pick_oh;
          state_d = sel_zero ? ST_DONE : ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        nrm_start = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (nrm_finish) state_d = ST_DONE;
      end
      ST_DONE: begin
        resp_valid = NUM_REQ'(1) << idx_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // The unit has no reset of its own; holding start clears its finish flag.
    if (reset) begin
      gnt        = '0;
      resp_valid = '0;
      nrm_start  = 1'b1;
      state_d    = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses nonblocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: all state here is plain registers, so everything is reset;
      // a RAM would be left unreset and qualified by valid flags instead.
      state_q <= ST_IDLE;
      idx_q   <= '0;
      rr_q    <= '0;
      nrm_vx  <= '0;
      nrm_vy  <= '0;
      nrm_vz  <= '0;
      res_x   <= '0;
      res_y   <= '0;
      res_z   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && pick_any) begin
        idx_q  <= pick_idx;
        nrm_vx <= sel_vx;
        nrm_vy <= sel_vy;
        nrm_vz <= sel_vz;
        if (sel_zero) begin
          res_x <= '0;
          res_y <= '0;
          res_z <= '0;
        end
      end
      if (state_q == ST_WAIT && nrm_finish) begin
        res_x <= nrm_rx;
        res_y <= nrm_ry;
        res_z <= nrm_rz;
      end
      if (state_q == ST_DONE) begin
        rr_q <= (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_normalize_arbiter.sv
// Self-checking bench for normalize_arbiter with a behavioural normalize unit
// (5-cycle start/finish latency). Expectations follow NRM_ARB_ZERO_BYPASS_EN.
module tb_normalize_arbiter;

  localparam int NR       = 4;
  localparam int DW       = 32;
  localparam int UNIT_LAT = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_vx, req_vy, req_vz;
  logic [NR-1:0]    gnt, resp_valid;
  logic [DW-1:0]    res_x, res_y, res_z;
  logic             nrm_start;
  logic [DW-1:0]    nrm_vx, nrm_vy, nrm_vz;
  logic             nrm_finish = 1'b0;
  logic [DW-1:0]    nrm_rx = '0, nrm_ry = '0, nrm_rz = '0;
  int               u_cnt = 0;

  int n_checks = 0;
  int n_errors = 0;

  normalize_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .IDX_W(2)) dut (
    .clk(clk), .reset(reset), .req(req),
    .req_vx(req_vx), .req_vy(req_vy), .req_vz(req_vz),
    .gnt(gnt), .resp_valid(resp_valid),
    .res_x(res_x), .res_y(res_y), .res_z(res_z),
    .nrm_start(nrm_start), .nrm_vx(nrm_vx), .nrm_vy(nrm_vy), .nrm_vz(nrm_vz),
    .nrm_finish(nrm_finish), .nrm_rx(nrm_rx), .nrm_ry(nrm_ry), .nrm_rz(nrm_rz)
  );

  initial forever #5 clk = ~clk;

  // ---------------- reference arithmetic ----------------
  function automatic longint isqrt(input longint v);
    longint r = 0;
    longint b = 64'sd1 <<< 62;
    longint t = v;
    while (b > t) b = b >>> 2;
    while (b != 0) begin
      if (t >= r + b) begin
        t = t - (r + b);
        r = (r >>> 1) + b;
      end else begin
        r = r >>> 1;
      end
      b = b >>> 2;
    end
    return r;
  endfunction

  // Component c of the unit vector along (x,y,z), all Q16.16.
  function automatic logic [31:0] nrm_ref(input logic [31:0] c, x, y, z);
    longint sx = longint'(signed'(x));
    longint sy = longint'(signed'(y));
    longint sz = longint'(signed'(z));
    longint s  = sx*sx + sy*sy + sz*sz;
    longint len;
    if (s == 0) return 32'h0;
    len = isqrt(s);
    return 32'((longint'(signed'(c)) * 65536) / len);
  endfunction

  // Rotate so the pointer sits at bit 0, lowest set bit wins.
  function automatic int pick_ref(input logic [NR-1:0] r, input int p);
    logic [2*NR-1:0] dbl;
    dbl = {r, r} >> p;
    for (int q = 0; q < NR; q++) if (dbl[q]) return (p + q) % NR;
    return -1;
  endfunction

  function automatic logic [31:0] rnd_comp();
    int v;
    v = int'($urandom_range(0, 8388607)) - 4194304;
    return 32'(v);
  endfunction

  // ---------------- behavioural normalize unit ----------------
  always @(posedge clk) begin
    if (nrm_start) begin
      nrm_finish <= 1'b0;
      u_cnt      <= UNIT_LAT;
    end else if (u_cnt != 0) begin
      u_cnt <= u_cnt - 1;
      if (u_cnt == 1) begin
        nrm_finish <= 1'b1;
        nrm_rx     <= nrm_ref(nrm_vx, nrm_vx, nrm_vy, nrm_vz);
        nrm_ry     <= nrm_ref(nrm_vy, nrm_vx, nrm_vy, nrm_vz);
        nrm_rz     <= nrm_ref(nrm_vz, nrm_vx, nrm_vy, nrm_vz);
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input logic [31:0] act, input logic [31:0] exp);
    int d;
    d = int'(signed'(act)) - int'(signed'(exp));
    n_checks++;
    if (d > 4 || d < -4) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h (+-4)", name, act, exp);
    end
  endtask

  // ---------------- transaction scoreboard ----------------
  initial begin
    bit            busy = 0;
    bit            was_busy;
    int            rr_m = 0;
    int            own = 0;
    int            busy_cyc = 0;
    int            w;
    logic [NR-1:0] exp_g;
    logic [95:0]   ev = '0, er = '0, last = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy = 0;
        rr_m = 0;
        last = '0;
      end else begin
        was_busy = busy;
        w = pick_ref(req, rr_m);
        exp_g = (was_busy || w < 0) ? '0 : NR'(1) << w;
        check("sb_gnt", gnt, exp_g);
        if (was_busy) begin
          check("sb_hold_nrm_v", {nrm_vx, nrm_vy, nrm_vz}, ev);
          busy_cyc++;
          if (busy_cyc > 40) begin
            check("sb_op_timeout", busy_cyc, 40);
            busy = 0;
          end
        end
        if (resp_valid != '0) begin
          check("sb_resp_owner", resp_valid, was_busy ? NR'(1) << own : '0);
          check("sb_res", {res_x, res_y, res_z}, er);
          last = er;
          rr_m = (own + 1) % NR;
          busy = 0;
        end else begin
          check("sb_res_hold", {res_x, res_y, res_z}, last);
        end
        if (!was_busy && w >= 0) begin
          own = w;
          busy = 1;
          busy_cyc = 0;
          ev = {req_vx[w*DW +: DW], req_vy[w*DW +: DW], req_vz[w*DW +: DW]};
          er = {nrm_ref(ev[95:64], ev[95:64], ev[63:32], ev[31:0]),
                nrm_ref(ev[63:32], ev[95:64], ev[63:32], ev[31:0]),
                nrm_ref(ev[31:0],  ev[95:64], ev[63:32], ev[31:0])};
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_vec(input int i, input logic [31:0] x, y, z);
    req_vx[i*DW +: DW] = x;
    req_vy[i*DW +: DW] = y;
    req_vz[i*DW +: DW] = z;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    req = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One request on requester i; cycle 0 is the cycle the request is raised.
  task automatic run_op(input int i, input logic [31:0] x, y, z, input bit drop_early,
                        output logic [31:0] rx, ry, rz,
                        output int gcyc, output int scyc, output int scnt, output int rcyc);
    gcyc = -1; scyc = -1; scnt = 0; rcyc = -1;
    rx = '0; ry = '0; rz = '0;
    @(posedge clk); #1;
    req[i] = 1'b1;
    set_vec(i, x, y, z);
    for (int c = 0; c < 100 && rcyc < 0; c++) begin
      @(negedge clk);
      if (gnt[i] && gcyc < 0) gcyc = c;
      if (nrm_start) begin
        scnt++;
        if (scyc < 0) scyc = c;
      end
      if (resp_valid[i]) begin
        rcyc = c;
        rx = res_x; ry = res_y; rz = res_z;
      end
      if (drop_early && c == gcyc) begin
        @(posedge clk); #1 req[i] = 1'b0;
      end
    end
    check("op_completes", rcyc >= 0, 1);
    @(posedge clk); #1 req[i] = 1'b0;
  endtask

  task automatic quiet(input int n, output int starts, output int gnts, output int resps);
    starts = 0; gnts = 0; resps = 0;
    repeat (n) begin
      @(negedge clk);
      if (nrm_start) starts++;
      if (gnt != '0) gnts++;
      if (resp_valid != '0) resps++;
    end
  endtask

  task automatic wait_gnt(output logic [NR-1:0] g);
    g = '0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (gnt != '0) begin
        g = gnt;
        break;
      end
    end
  endtask

  task automatic wait_resp(input int i);
    bit ok = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (resp_valid[i]) begin
        ok = 1;
        break;
      end
    end
    check("wait_resp", ok, 1);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int          idx;
    logic [31:0] vx, vy, vz;
    logic [31:0] ex, ey, ez;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0]   rx, ry, rz;
    int            gcyc, scyc, scnt, rcyc;
    int            st, gn, rs;
    int            order[5];
    int            n;
    logic [NR-1:0] g;
    bit [NR-1:0]   gs, rsd;

    tbl[0] = '{0, 32'h0003_0000, 32'h0004_0000, 32'h0000_0000, 32'h0000_9999, 32'h0000_CCCC, 32'h0000_0000};
    tbl[1] = '{1, 32'h0000_0000, 32'h0000_0000, 32'h0002_0000, 32'h0000_0000, 32'h0000_0000, 32'h0001_0000};
    tbl[2] = '{2, 32'hFFFF_0000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_0000, 32'h0000_0000, 32'h0000_0000};
    tbl[3] = '{3, 32'h0000_0000, 32'h0005_0000, 32'h000C_0000, 32'h0000_0000, 32'h0000_6276, 32'h0000_EC4E};
    tbl[4] = '{1, 32'h0002_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_AAAA, 32'h0000_AAAA, 32'h0000_5555};
    tbl[5] = '{2, 32'h0000_0000, 32'hFFFD_0000, 32'hFFFC_0000, 32'h0000_0000, 32'hFFFF_6667, 32'hFFFF_3334};

    reset = 1'b1;
    req = '0;
    req_vx = '0; req_vy = '0; req_vz = '0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_gnt", gnt, '0);
    check("rst_resp", resp_valid, '0);
    check("rst_start", nrm_start, 1);
    check("rst_res", {res_x, res_y, res_z}, '0);
    check("rst_nrm_v", {nrm_vx, nrm_vy, nrm_vz}, '0);
    @(posedge clk); #1 reset = 1'b0;

    // Single-requester table (first entry is the 3-4-0 latency case)
    foreach (tbl[k]) begin
      run_op(tbl[k].idx, tbl[k].vx, tbl[k].vy, tbl[k].vz, 1'b0, rx, ry, rz, gcyc, scyc, scnt, rcyc);
      check("tbl_gnt_cycle", gcyc, 0);
      check("tbl_start_cycle", scyc, 1);
      check("tbl_start_count", scnt, 1);
      check_near("tbl_res_x", rx, tbl[k].ex);
      check_near("tbl_res_y", ry, tbl[k].ey);
      check_near("tbl_res_z", rz, tbl[k].ez);
      quiet(4, st, gn, rs);
      check("tbl_quiet_start", st, 0);
      check("tbl_quiet_resp", rs, 0);
    end

    // All four requesting continuously: grants 0,1,2,3,0
    do_reset();
    for (int i = 0; i < NR; i++) set_vec(i, rnd_comp(), rnd_comp(), rnd_comp());
    req = '1;
    n = 0;
    for (int c = 0; c < 200 && n < 5; c++) begin
      @(negedge clk);
      for (int q = 0; q < NR; q++) if (gnt[q]) begin
        order[n] = q;
        n++;
      end
    end
    check("rr_grant_count", n, 5);
    for (int k = 0; k < 5; k++) check("rr_order", order[k], k % NR);
    wait_resp(0);
    @(posedge clk); #1 req = '0;
    quiet(3, st, gn, rs);

    // Request dropped one cycle after grant still completes, nothing extra
    run_op(2, 32'h0001_0000, 32'h0002_0000, 32'h0002_0000, 1'b1, rx, ry, rz, gcyc, scyc, scnt, rcyc);
    check("drop_gnt_cycle", gcyc, 0);
    check_near("drop_res_x", rx, 32'h0000_5555);
    check_near("drop_res_z", rz, 32'h0000_AAAA);
    quiet(15, st, gn, rs);
    check("drop_no_start", st, 0);
    check("drop_no_gnt", gn, 0);
    check("drop_no_resp", rs, 0);

    // Reset while waiting on the unit
    @(posedge clk); #1;
    req[1] = 1'b1;
    set_vec(1, 32'h0004_0000, 32'h0000_0000, 32'h0003_0000);
    wait_gnt(g);
    check("abort_gnt", g, 4'b0010);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("abort_start_in_reset", nrm_start, 1);
    check("abort_resp", resp_valid, '0);
    @(posedge clk); #1 req[1] = 1'b0;
    @(negedge clk);
    check("abort_res", {res_x, res_y, res_z}, '0);
    check("abort_nrm_v", {nrm_vx, nrm_vy, nrm_vz}, '0);
    check("abort_start_held", nrm_start, 1);
    check("abort_resp2", resp_valid, '0);
    @(posedge clk); #1 reset = 1'b0;
    quiet(12, st, gn, rs);
    check("abort_no_resp", rs, 0);
    check("abort_no_gnt", gn, 0);
    run_op(1, 32'h0004_0000, 32'h0000_0000, 32'h0003_0000, 1'b0, rx, ry, rz, gcyc, scyc, scnt, rcyc);
    check_near("abort_next_x", rx, 32'h0000_CCCC);
    check_near("abort_next_z", rz, 32'h0000_9999);

    // Zero vector
    run_op(3, 32'h0, 32'h0, 32'h0, 1'b0, rx, ry, rz, gcyc, scyc, scnt, rcyc);
    check("zero_gnt_cycle", gcyc, 0);
`ifdef NRM_ARB_ZERO_BYPASS_EN
    check("zero_resp_cycle", rcyc, 1);
    check("zero_no_start", scnt, 0);
    check("zero_res", {rx, ry, rz}, '0);
`else
    check("zero_start_count", scnt, 1);
    check("zero_start_cycle", scyc, 1);
    check("zero_full_seq", rcyc > 2, 1);
`endif
    quiet(3, st, gn, rs);

    // Continuous req[1] with req[0] arriving mid-op: pointer wraps to 0
    do_reset();
    @(posedge clk); #1;
    req[1] = 1'b1;
    set_vec(1, 32'h0000_0000, 32'h0003_0000, 32'h0000_0000);
    wait_gnt(g);
    check("wrap_first", g, 4'b0010);
    repeat (2) @(posedge clk);
    #1 req[0] = 1'b1;
    set_vec(0, 32'h0000_0000, 32'h0000_0000, 32'hFFFE_0000);
    wait_gnt(g);
    check("wrap_second", g, 4'b0001);
    wait_resp(0);
    @(posedge clk); #1 req[0] = 1'b0;
    wait_gnt(g);
    check("wrap_third", g, 4'b0010);
    wait_resp(1);
    @(posedge clk); #1 req[1] = 1'b0;
    quiet(3, st, gn, rs);

    // Randomized traffic; the scoreboard checks grant order, hold and results
    gs = '0;
    rsd = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      gs  = gs | gnt;
      rsd = rsd | resp_valid;
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (req[i] && rsd[i]) begin
          req[i] = 1'b0;
          rsd[i] = 1'b0;
          gs[i]  = 1'b0;
        end else if (req[i] && gs[i] && $urandom_range(0, 2) == 0) begin
          set_vec(i, rnd_comp(), rnd_comp(), rnd_comp());
        end
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          if ($urandom_range(0, 15) == 0) set_vec(i, 32'h0, 32'h0, 32'h0);
          else set_vec(i, rnd_comp(), rnd_comp(), rnd_comp());
        end
      end
    end
    req = '0;
    repeat (40) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
